idex_pipe_reg: RTL and testbench

Parametrised ID/EX pipeline register for the RISC-V core. It sits between the decode stage and the execute stage and replaces the fixed-width, free-running register. It adds a valid/ready handshake, stall back-pressure, a synchronous flush that injects an all-zero control bubble, and an optional one-entry skid buffer that registers the upstream ready path. A saturating bubble counter supports pipeline-efficiency measurement.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/pipe_skid_buf.sv | 25 ++
 rtl/idex_pipe_reg.sv | 80 ++++++++
 tb/tb_idex_pipe_reg.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared control-word layout, datapath word indices and ID/EX state encoding
package riscv_pkg;
  localparam int CTRL_W        = 16;
  localparam int CTRL_W_REG    = 15;
  localparam int CTRL_BRANCH   = 14;
  localparam int CTRL_ALUSRC   = 13;
  localparam int CTRL_PC_SEL   = 12;
  localparam int CTRL_R_DM     = 9;
  localparam int CTRL_ALU_OP   = 4;
  localparam int CTRL_W_DM     = 2;
  localparam int CTRL_REG_DEST = 0;
  localparam int IDX_DATA1     = 0;
  localparam int IDX_DATA2     = 1;
  localparam int IDX_IMM       = 2;
  localparam int IDX_PC        = 3;
  localparam int IDX_PC4       = 4;
  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_FULL_SKID} pipe_state_e;
  function automatic logic ctrl_writes(input logic [CTRL_W-1:0] c);
    return c[CTRL_W_REG] | (|c[CTRL_W_DM +: 2]);
  endfunction
endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: payload register with valid bit (clk, rst_n, ld_i loads d_i, vld_d_i next valid, vld_o/q_o held entry)
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic         vld_d_i,
  input  logic [W-1:0] d_i,
  output logic         vld_o,
  output logic [W-1:0] q_o
);
  logic         vld_q;
  logic [W-1:0] data_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q <= vld_d_i;
      if (ld_i) data_q <= d_i;
    end
  assign vld_o = vld_q;
  assign q_o   = data_q;
endmodule

// File: rtl/idex_pipe_reg.sv
// idex_pipe_reg: ID/EX register with valid/ready, flush bubble, optional skid entry and saturating bubble counter
module idex_pipe_reg #(
  parameter int XLEN      = 32,
  parameter int NUM_WORDS = 5,
  parameter int CTRL_W    = riscv_pkg::CTRL_W,
  parameter int SKID      = 1,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [NUM_WORDS*XLEN-1:0] in_data,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [NUM_WORDS*XLEN-1:0] out_data,
  output logic [CNT_W-1:0]          bubble_cnt
);
  import riscv_pkg::*;
  localparam int DW = NUM_WORDS * XLEN;
  localparam int PW = CTRL_W + DW;
  pipe_state_e     state_q, state_d;
  logic            in_xfer, out_xfer, main_ld, skid_ld, skid_valid;
  logic [PW-1:0]   main_q, main_d, skid_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign in_ready = (SKID != 0) ? !skid_valid : (!out_valid | out_ready);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  always_comb begin
    state_d = flush ? ST_EMPTY :
              state_q == ST_EMPTY ? (in_xfer ? ST_FULL : ST_EMPTY) :
              state_q == ST_FULL  ? (out_xfer ? (in_xfer ? ST_FULL : ST_EMPTY)
                                              : (in_xfer ? ST_FULL_SKID : ST_FULL)) :
              (out_xfer ? ST_FULL : ST_FULL_SKID);
    main_ld = !flush & ((state_q == ST_FULL_SKID) ? out_xfer
                                                  : in_xfer & (state_q == ST_EMPTY | out_xfer));
    skid_ld = !flush & (state_q == ST_FULL) & in_xfer & !out_xfer;
    main_d  = (state_q == ST_FULL_SKID) ? skid_q : {in_ctrl, in_data};
    cnt_d   = (!out_valid && cnt_q != {CNT_W{1'b1}}) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  pipe_skid_buf #(.W(PW)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_i    (main_ld),
    .vld_d_i (state_d != ST_EMPTY),
    .d_i     (main_d),
    .vld_o   (out_valid),
    .q_o     (main_q)
  );
  generate
    if (SKID != 0) begin : g_skid
      pipe_skid_buf #(.W(PW)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_i    (skid_ld),
        .vld_d_i (state_d == ST_FULL_SKID),
        .d_i     ({in_ctrl, in_data}),
        .vld_o   (skid_valid),
        .q_o     (skid_q)
      );
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_q     = '0;
    end
  endgenerate
  assign out_ctrl   = out_valid ? main_q[PW-1 -: CTRL_W] : CTRL_W'(CTRL_NOP);
  assign out_data   = main_q[DW-1:0];
  assign bubble_cnt = cnt_q;
endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb_idex_pipe_reg: directed checks of ID/EX register for SKID=1 and SKID=0/CNT_W=4 builds
module tb_idex_pipe_reg;
  import riscv_pkg::*;
  localparam int XL = 32;
  localparam int DW = 5 * XL;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [15:0] in_ctrl, out_ctrl, bubble_cnt;
  logic [DW-1:0] in_data, out_data;
  logic rst0_n, in_valid0, in_ready0, flush0, out_valid0, out_ready0;
  logic [15:0] in_ctrl0, out_ctrl0;
  logic [3:0] bubble_cnt0;
  logic [DW-1:0] in_data0, out_data0;
  int vectors = 0, miscompares = 0;
  bit cur_ov, cur_ov0;
  int exp_bub, exp_bub0;
  idex_pipe_reg #(.XLEN(32), .NUM_WORDS(5), .CTRL_W(16), .SKID(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .bubble_cnt(bubble_cnt));
  idex_pipe_reg #(.XLEN(32), .NUM_WORDS(5), .CTRL_W(16), .SKID(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst0_n), .in_valid(in_valid0), .in_ready(in_ready0), .in_ctrl(in_ctrl0),
    .in_data(in_data0), .flush(flush0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .bubble_cnt(bubble_cnt0));
  function automatic logic [DW-1:0] mk(input logic [31:0] pc);
    return {pc + 32'd4, pc, 32'h0000_0ABC, pc ^ 32'h5555_0000, pc ^ 32'h0000_AAAA};
  endfunction
  task automatic tick(input bit ov);
    if (!cur_ov) exp_bub++;
    @(posedge clk); #1;
    cur_ov = ov;
  endtask
  task automatic tick0(input bit ov);
    if (!cur_ov0 && exp_bub0 < 15) exp_bub0++;
    @(posedge clk); #1;
    cur_ov0 = ov;
  endtask
  task automatic push(input logic [31:0] pc, input logic [15:0] c);
    in_valid = 1'b1; in_data = mk(pc); in_ctrl = c;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; rst0_n = 1'b0;
    in_valid = 0; flush = 0; out_ready = 0; in_ctrl = '0; in_data = '0;
    in_valid0 = 0; flush0 = 0; out_ready0 = 0; in_ctrl0 = '0; in_data0 = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (out_ctrl !== 16'h0) begin miscompares++; $display("FAIL reset_out_ctrl: got %h want 0000", out_ctrl); end
    vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    vectors++; if (bubble_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_bubble: got %0d want 0", bubble_cnt); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (in_ready0 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready_skid0: got %b want 1", in_ready0); end
    vectors++; if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid_skid0: got %b want 0", out_valid0); end
    rst_n = 1'b1; cur_ov = 0; exp_bub = 0;
  endtask
  task automatic test_stream;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(32'(i * 4), 16'h1000 | 16'(i));
      tick(1);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stream_valid[%0d]: got %b want 1", i, out_valid); end
      vectors++; if (out_data !== mk(32'(i * 4))) begin miscompares++; $display("FAIL stream_data[%0d]: got pc %h want %h", i, out_data[IDX_PC*XL +: XL], i * 4); end
      vectors++; if (out_ctrl !== (16'h1000 | 16'(i))) begin miscompares++; $display("FAIL stream_ctrl[%0d]: got %h want %h", i, out_ctrl, 16'h1000 | 16'(i)); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    vectors++; if (bubble_cnt !== 16'd1) begin miscompares++; $display("FAIL stream_bubble: got %0d want 1", bubble_cnt); end
    tick(0);
    vectors++; if (out_valid !== 1'b0 || out_ctrl !== 16'h0) begin miscompares++; $display("FAIL stream_drain: got valid %b ctrl %h want 0 0000", out_valid, out_ctrl); end
  endtask
  task automatic test_stall_skid;
    out_ready = 1'b0;
    push(32'h100, 16'h2100); tick(1);
    vectors++; if (out_data[IDX_PC*XL +: XL] !== 32'h100 || in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_load: got pc %h rdy %b want 100 1", out_data[IDX_PC*XL +: XL], in_ready); end
    push(32'h104, 16'h2104); tick(1);
    vectors++; if (out_data[IDX_PC*XL +: XL] !== 32'h100 || in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_skid_fill: got pc %h rdy %b want 100 0", out_data[IDX_PC*XL +: XL], in_ready); end
    push(32'h108, 16'h2108); tick(1);
    vectors++; if (out_data[IDX_PC*XL +: XL] !== 32'h100 || in_ready !== 1'b0 || out_ctrl !== 16'h2100) begin miscompares++; $display("FAIL stall_hold: got pc %h rdy %b ctrl %h want 100 0 2100", out_data[IDX_PC*XL +: XL], in_ready, out_ctrl); end
    in_valid = 1'b0; out_ready = 1'b1; tick(1);
    vectors++; if (out_data !== mk(32'h104) || out_ctrl !== 16'h2104 || out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_skid_out: got pc %h ctrl %h want 104 2104", out_data[IDX_PC*XL +: XL], out_ctrl); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_ready_back: got %b want 1", in_ready); end
    tick(0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_no_dup: got valid %b pc %h want 0", out_valid, out_data[IDX_PC*XL +: XL]); end
    vectors++; if (bubble_cnt !== 16'(exp_bub)) begin miscompares++; $display("FAIL stall_bubble: got %0d want %0d", bubble_cnt, exp_bub); end
  endtask
  task automatic test_flush;
    out_ready = 1'b0;
    push(32'h300, 16'h3300); tick(1);
    push(32'h304, 16'h3304); tick(1);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_setup_ready: got %b want 0", in_ready); end
    flush = 1'b1; push(32'h200, 16'hFFFF); tick(0);
    vectors++; if (out_valid !== 1'b0 || out_ctrl !== 16'h0) begin miscompares++; $display("FAIL flush_skid: got valid %b ctrl %h want 0 0000", out_valid, out_ctrl); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %b want 1", in_ready); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick(0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_no_200: got valid %b pc %h want 0", out_valid, out_data[IDX_PC*XL +: XL]); end
    push(32'h400, 16'h3400); tick(1);
    flush = 1'b1; push(32'h200, 16'hFFFF); tick(0);
    vectors++; if (out_valid !== 1'b0 || out_ctrl !== 16'h0) begin miscompares++; $display("FAIL flush_full: got valid %b ctrl %h want 0 0000", out_valid, out_ctrl); end
    flush = 1'b0; in_valid = 1'b0; tick(0);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_full_discard: got valid %b want 0", out_valid); end
  endtask
  task automatic test_bubble_ctrl;
    out_ready = 1'b1;
    push(32'h500, 16'hFFFF); tick(1);
    vectors++; if (out_ctrl !== 16'hFFFF) begin miscompares++; $display("FAIL bubble_ctrl_live: got %h want ffff", out_ctrl); end
    in_valid = 1'b0; tick(0);
    vectors++; if (out_ctrl !== 16'h0 || ctrl_writes(out_ctrl)) begin miscompares++; $display("FAIL bubble_ctrl_zero: got %h want 0000", out_ctrl); end
    for (int i = 0; i < 3; i++) begin
      tick(0);
      vectors++; if (bubble_cnt !== 16'(exp_bub)) begin miscompares++; $display("FAIL bubble_count[%0d]: got %0d want %0d", i, bubble_cnt, exp_bub); end
    end
  endtask
  task automatic test_async_reset;
    out_ready = 1'b0;
    push(32'h600, 16'h4600); tick(1);
    push(32'h604, 16'h4604); tick(1);
    in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL areset_setup: got rdy %b valid %b want 0 1", in_ready, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || out_ctrl !== 16'h0 || out_data !== '0) begin miscompares++; $display("FAIL areset_outputs: got valid %b ctrl %h pc %h want 0", out_valid, out_ctrl, out_data[IDX_PC*XL +: XL]); end
    vectors++; if (bubble_cnt !== 16'd0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL areset_state: got cnt %0d rdy %b want 0 1", bubble_cnt, in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1; cur_ov = 0; exp_bub = 0;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_release: got rdy %b valid %b want 1 0", in_ready, out_valid); end
    out_ready = 1'b1;
    push(32'h700, 16'h4700); tick(1);
    vectors++; if (out_data !== mk(32'h700) || out_ctrl !== 16'h4700) begin miscompares++; $display("FAIL areset_recover: got pc %h ctrl %h want 700 4700", out_data[IDX_PC*XL +: XL], out_ctrl); end
    vectors++; if (bubble_cnt !== 16'd1) begin miscompares++; $display("FAIL areset_bubble: got %0d want 1", bubble_cnt); end
    in_valid = 1'b0;
  endtask
  task automatic test_skid0;
    rst0_n = 1'b1; cur_ov0 = 0; exp_bub0 = 0;
    out_ready0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid0 = 1'b1; in_data0 = mk(32'(i * 4)); in_ctrl0 = 16'h5000 | 16'(i);
      tick0(1);
      vectors++; if (out_valid0 !== 1'b1 || out_data0 !== mk(32'(i * 4))) begin miscompares++; $display("FAIL s0_stream[%0d]: got valid %b pc %h want 1 %h", i, out_valid0, out_data0[IDX_PC*XL +: XL], i * 4); end
      vectors++; if (in_ready0 !== 1'b1) begin miscompares++; $display("FAIL s0_stream_ready[%0d]: got %b want 1", i, in_ready0); end
    end
    vectors++; if (bubble_cnt0 !== 4'd1) begin miscompares++; $display("FAIL s0_stream_bubble: got %0d want 1", bubble_cnt0); end
    out_ready0 = 1'b0; in_data0 = mk(32'h100); in_ctrl0 = 16'h5100;
    #1;
    vectors++; if (in_ready0 !== 1'b0) begin miscompares++; $display("FAIL s0_comb_stall: got %b want 0", in_ready0); end
    tick0(1);
    vectors++; if (out_data0 !== mk(32'h1C) || out_ctrl0 !== 16'h5007) begin miscompares++; $display("FAIL s0_hold: got pc %h ctrl %h want 1c 5007", out_data0[IDX_PC*XL +: XL], out_ctrl0); end
    out_ready0 = 1'b1;
    #1;
    vectors++; if (in_ready0 !== 1'b1) begin miscompares++; $display("FAIL s0_comb_ready: got %b want 1", in_ready0); end
    tick0(1);
    vectors++; if (out_data0 !== mk(32'h100) || out_ctrl0 !== 16'h5100) begin miscompares++; $display("FAIL s0_replace: got pc %h ctrl %h want 100 5100", out_data0[IDX_PC*XL +: XL], out_ctrl0); end
    in_valid0 = 1'b0;
    for (int i = 0; i < 20; i++) tick0(0);
    vectors++; if (bubble_cnt0 !== 4'd15 || exp_bub0 != 15) begin miscompares++; $display("FAIL s0_saturate: got %0d want 15", bubble_cnt0); end
    vectors++; if (out_ctrl0 !== 16'h0) begin miscompares++; $display("FAIL s0_idle_ctrl: got %h want 0000", out_ctrl0); end
  endtask
  initial begin
    test_reset;
    test_stream;
    test_stall_skid;
    test_flush;
    test_bubble_ctrl;
    test_async_reset;
    test_skid0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
